// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-channel 2-flop synchroniser, debounce counter,
// registered rise/fall pulses, and a show-ahead event FIFO of edge snapshots
// with a sticky overflow flag.
module gpio_input_conditioner #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [NUM_CH-1:0]     gpio_in,
    output logic [NUM_CH-1:0]     level_out,
    output logic [NUM_CH-1:0]     rise_pulse,
    output logic [NUM_CH-1:0]     fall_pulse,
    output logic                  evt_valid,
    output logic [2*NUM_CH-1:0]   evt_data,
    input  logic                  evt_pop,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 2 * NUM_CH;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              push, pop, full, wr_en, drop;

    // Two-stage synchroniser, free-running regardless of en
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive mismatches, flip level and pulse on the last one
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!en) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so push+pop when full is lossless
    always_comb begin
        push       = |(rise_q | fall_q);
        pop        = evt_pop && (count_q != '0);
        full       = (count_q == (AW+1)'(FIFO_DEPTH));
        wr_en      = push && (!full || pop);
        drop       = push && full && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO storage, pointers and sticky overflow
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {rise_q, fall_q};
            end
        end
    end

    // Output mapping; head is shown ahead and masked to zero when empty
    always_comb begin
        level_out  = level_q;
        rise_pulse = rise_q;
        fall_pulse = fall_q;
        overflow   = overflow_q;
        evt_valid  = (count_q != '0);
        evt_data   = evt_valid ? mem_q[rd_ptr_q] : '0;
    end

endmodule
